line_window_gen: RTL and testbench
==================================

LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
REQ-001 Parameter K, default 3: window side length; odd, 3..7.
REQ-002 Parameter DATA_W, default 8: pixel width in bits.
REQ-003 Parameter MAX_W, default 512: maximum image width; sets line-buffer depth.
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s_axis_tdata  input  DATA_W  input pixel, raster order.
REQ-007 s_axis_tvalid  input  1  input beat valid.
REQ-008 s_axis_tready  output  1  input beat accepted when tvalid and tready are both high.
REQ-009 IMG_W_I  input  10  frame width in pixels.
REQ-010 IMG_H_I  input  10  frame height in pixels.
REQ-011 m_window_o  output  K*K*DATA_W  window; element (i,j) at bits [(i*K+j)*DATA_W +: DATA_W], i = row offset (0 = oldest row), j = column offset (0 = leftmost).
REQ-012 m_valid_o  output  1  window valid.
REQ-013 m_ready_i  input  1  downstream accepts window.
REQ-014 m_last_o  output  1  high with the final window of the frame.
REQ-015 frame_done_o  output  1  one-cycle pulse at frame end.
REQ-016 size_err_o  output  1  current frame has illegal dimensions.

Function
REQ-017 The block SHALL drive s_axis_tready = !m_valid_o || m_ready_i, combinationally; out of reset it SHALL be high.
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-019 IDLE: on the first accepted beat, latch IMG_W_I/IMG_H_I and go to RUN; the size inputs are ignored at all other times.
REQ-020 RUN: col counter steps 0..W-1, then wraps to 0 and row increments; on acceptance of pixel (H-1, W-1), go to DONE.
REQ-021 DONE: once no window is pending (m_valid_o low, or the m_last_o window is handshaked), pulse frame_done_o for one cycle and return to IDLE.
REQ-022 In DONE, s_axis_tready SHALL be low.
REQ-023 K-1 line buffers of MAX_W x DATA_W SHALL hold previous rows; a K x K register array SHALL shift left by one column per accepted beat.
REQ-024 Window emission SHALL be valid-mode only: a window is emitted for an accepted pixel (r,c) iff r >= K-1 and c >= K-1.
REQ-025 That window SHALL cover rows r-K+1..r and cols c-K+1..c, giving (W-K+1)*(H-K+1) windows per frame.
REQ-026 Latency SHALL be 1 cycle: m_valid_o and m_window_o rise on the edge after the producing beat is accepted.
REQ-027 m_window_o, m_valid_o and m_last_o SHALL hold stable while m_valid_o && !m_ready_i.
REQ-028 m_valid_o SHALL clear on handshake unless a new window is produced in the same cycle.
REQ-029 Windows SHALL never straddle the column wrap, so no stale left-edge data appears.
REQ-030 m_last_o SHALL be high only on the window for pixel (H-1, W-1).
REQ-031 Illegal dimensions: W < K, H < K, or W > MAX_W.
REQ-032 With illegal dimensions, size_err_o SHALL be high from latch until frame_done_o.
REQ-033 With illegal dimensions, all W*H beats SHALL be accepted and discarded, no window emitted, and frame_done_o still pulsed.
REQ-034 If a beat is accepted in the same cycle that a window is handshaked, both SHALL take effect with no beat lost or duplicated.
REQ-035 Line-buffer contents SHALL NOT be cleared between frames; validity comes only from the counters.

Reset
REQ-036 rst_n low SHALL force IDLE and zero the col/row counters.
REQ-037 Reset values: m_valid_o = 0, m_last_o = 0, frame_done_o = 0, size_err_o = 0, m_window_o = 0, s_axis_tready = 1.
REQ-038 Reset mid-frame SHALL abandon the frame; the next accepted beat starts a new frame as pixel (0,0).
REQ-039 Line-buffer RAM SHALL need no reset.

Verification
REQ-040 K=3, 9x9, pixel value = index 0..80, m_ready_i=1 -> 49 windows; first = {0,1,2,9,10,11,18,19,20}; last = {60,61,62,69,70,71,78,79,80} with m_last_o=1; frame_done_o pulses once.
REQ-041 Same frame, m_ready_i held low 5 cycles at window 10 -> s_axis_tready low during the stall, window 10 held stable, 49 windows delivered in order, none lost or duplicated.
REQ-042 9x9 frame, then IMG_W_I=7, IMG_H_I=5 changed in IDLE -> second frame yields 15 windows; first = {0,1,2,7,8,9,14,15,16} of the new ramp.
REQ-043 K=3, IMG_W_I=2, IMG_H_I=2 -> size_err_o=1, 4 beats accepted, m_valid_o never high, one frame_done_o pulse, size_err_o low afterwards.
REQ-044 rst_n pulsed low after 40 beats of a 9x9 frame, then a full 9x9 ramp -> output identical to REQ-040.
REQ-045 K=5, 9x9 ramp -> 25 windows; first window row 0 = {0,1,2,3,4}, row 4 = {36,37,38,39,40}.

Source files
------------

// File: rtl/line_window_gen.sv
// Sliding K x K window generator over a raster pixel stream.
// K-1 line buffers feed a K x K shift array; only fully-inside windows are emitted.
module line_window_gen #(
   parameter int unsigned K      = 3,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned MAX_W  = 512
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [9:0]              IMG_W_I,
   input  logic [9:0]              IMG_H_I,
   output logic [K*K*DATA_W-1:0]   m_window_o,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic                    m_last_o,
   output logic                    frame_done_o,
   output logic                    size_err_o
);

   localparam int unsigned DIM_W = 10;
   localparam int unsigned AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [DIM_W-1:0] KD  = DIM_W'(K);
   localparam logic [DIM_W-1:0] KM1 = DIM_W'(K - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t            state;
   logic [DIM_W-1:0]  col_q;
   logic [DIM_W-1:0]  row_q;
   logic [DIM_W-1:0]  w_q;
   logic [DIM_W-1:0]  h_q;

   logic [DIM_W-1:0]  w_cur;
   logic [DIM_W-1:0]  h_cur;
   logic              accept;
   logic              dims_ok;
   logic              col_end;
   logic              last_pix;
   logic              emit;
   logic [AW-1:0]     addr;
   logic [DATA_W-1:0] col_pix [K];

   // Row 0 is the oldest stored row; no reset, validity comes from the counters.
   logic [DATA_W-1:0] line_buf [0:K-2][MAX_W];

   // Dimensions come straight from the inputs on the first beat, then from the latch.
   always_comb begin
      s_axis_tready = (state != DONE) && (!m_valid_o || m_ready_i);
      accept        = s_axis_tvalid && s_axis_tready;
      w_cur         = (state == IDLE) ? IMG_W_I : w_q;
      h_cur         = (state == IDLE) ? IMG_H_I : h_q;
      dims_ok       = (w_cur >= KD) && (h_cur >= KD) && (32'(w_cur) <= MAX_W);
      col_end       = (col_q == (w_cur - DIM_W'(1)));
      last_pix      = col_end && (row_q == (h_cur - DIM_W'(1)));
      emit          = accept && dims_ok && (row_q >= KM1) && (col_q >= KM1);
      addr          = AW'(col_q);
      for (int i = 0; i < int'(K) - 1; i++) begin
         col_pix[i] = line_buf[i][addr];
      end
      col_pix[K-1] = s_axis_tdata;
   end

   // Each buffer row moves up by one as the new pixel enters the column.
   always_ff @(posedge clk) begin
      if (accept && dims_ok) begin
         for (int i = 0; i < int'(K) - 1; i++) begin
            line_buf[i][addr] <= col_pix[i+1];
         end
      end
   end

   // Control FSM, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         w_q          <= '0;
         h_q          <= '0;
         m_window_o   <= '0;
         m_valid_o    <= 1'b0;
         m_last_o     <= 1'b0;
         frame_done_o <= 1'b0;
         size_err_o   <= 1'b0;
      end else begin
         frame_done_o <= 1'b0;

         // Window array shifts left; the new column enters at j = K-1.
         if (accept && dims_ok) begin
            for (int i = 0; i < int'(K); i++) begin
               for (int j = 0; j < int'(K); j++) begin
                  if (j == int'(K) - 1) begin
                     m_window_o[(i*K+j)*DATA_W +: DATA_W] <= col_pix[i];
                  end else begin
                     m_window_o[(i*K+j)*DATA_W +: DATA_W] <=
                        m_window_o[(i*K+j+1)*DATA_W +: DATA_W];
                  end
               end
            end
         end

         if (emit) begin
            m_valid_o <= 1'b1;
            m_last_o  <= last_pix;
         end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (accept) begin
                  w_q        <= IMG_W_I;
                  h_q        <= IMG_H_I;
                  size_err_o <= !dims_ok;
               end
            end
            RUN: ;
            DONE: begin
               if (!m_valid_o || m_ready_i) begin
                  frame_done_o <= 1'b1;
                  size_err_o   <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Accepts never occur in DONE because tready is held low there.
         if (accept) begin
            if (last_pix) begin
               col_q <= '0;
               row_q <= '0;
               state <= DONE;
            end else if (col_end) begin
               col_q <= '0;
               row_q <= row_q + DIM_W'(1);
               state <= RUN;
            end else begin
               col_q <= col_q + DIM_W'(1);
               state <= RUN;
            end
         end
      end
   end

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen: K=3 and K=5 instances driven with ramp frames.
module tb_line_window_gen;

   localparam int unsigned DW   = 8;
   localparam int unsigned WMAX = 5 * 5 * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [9:0]    img_w, img_h;

   logic [DW-1:0] tdata;
   logic          tvalid, tready;
   logic [71:0]   win;
   logic          valid, ready, last, done, err;

   logic [DW-1:0] k5_tdata;
   logic          k5_tvalid, k5_tready;
   logic [199:0]  k5_win;
   logic          k5_valid, k5_ready, k5_last, k5_done, k5_err;

   int errors = 0;
   int checks = 0;

   logic [WMAX-1:0] win_q[$];
   logic            last_q[$];
   logic [WMAX-1:0] k5_q[$];
   logic            k5_last_q[$];
   int done_cnt, acc_cnt, vseen, k5_done_cnt;

   line_window_gen #(.K(3), .DATA_W(DW), .MAX_W(512)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
      .IMG_W_I(img_w), .IMG_H_I(img_h),
      .m_window_o(win), .m_valid_o(valid), .m_ready_i(ready),
      .m_last_o(last), .frame_done_o(done), .size_err_o(err)
   );

   line_window_gen #(.K(5), .DATA_W(DW), .MAX_W(512)) dut5 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(k5_tdata), .s_axis_tvalid(k5_tvalid), .s_axis_tready(k5_tready),
      .IMG_W_I(img_w), .IMG_H_I(img_h),
      .m_window_o(k5_win), .m_valid_o(k5_valid), .m_ready_i(k5_ready),
      .m_last_o(k5_last), .frame_done_o(k5_done), .size_err_o(k5_err)
   );

   always #5 clk = ~clk;

   // Inputs change at posedge+1, so negedge sees exactly what the next edge will act on.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid && ready) begin
            win_q.push_back(WMAX'(win));
            last_q.push_back(last);
         end
         if (valid) vseen++;
         if (tvalid && tready) acc_cnt++;
         if (done) done_cnt++;
         if (k5_valid && k5_ready) begin
            k5_q.push_back(k5_win);
            k5_last_q.push_back(k5_last);
         end
         if (k5_done) k5_done_cnt++;
      end
   end

   // Window for pixel (r,c) of a ramp frame of width w, element (i,j) at (i*kk+j)*8.
   function automatic logic [WMAX-1:0] exp_win(int kk, int w, int r, int c);
      logic [WMAX-1:0] v;
      v = '0;
      for (int i = 0; i < kk; i++)
         for (int j = 0; j < kk; j++)
            v[(i*kk+j)*DW +: DW] = DW'((r - kk + 1 + i) * w + (c - kk + 1 + j));
      return v;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear();
      win_q.delete(); last_q.delete(); k5_q.delete(); k5_last_q.delete();
      done_cnt = 0; acc_cnt = 0; vseen = 0; k5_done_cnt = 0;
   endtask

   task automatic send_beats(int w, int h, int n);
      int waited;
      img_w = 10'(w); img_h = 10'(h);
      for (int i = 0; i < n; i++) begin
         tdata = DW'(i); tvalid = 1'b1; waited = 0;
         forever begin
            @(negedge clk);
            if (tready) break;
            waited++;
            if (waited > 200) begin
               checks++; errors++;
               $display("FAIL send_timeout beat=%0d tready=%b want=1", i, tready);
               break;
            end
         end
         step();
      end
      tvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tvalid = 1'b0; k5_tvalid = 1'b0; ready = 1'b1; k5_ready = 1'b1;
      tdata = '0; k5_tdata = '0; img_w = 10'd9; img_h = 10'd9;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
      checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b want=0", last); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
      checks++; if (win !== 72'd0) begin errors++; $display("FAIL reset_window got=%h want=0", win); end
      checks++; if (tready !== 1'b1) begin errors++; $display("FAIL reset_tready got=%b want=1", tready); end
      step();
   endtask

   task automatic test_frame();
      logic [71:0] first_c, last_c;
      first_c = {8'd20, 8'd19, 8'd18, 8'd11, 8'd10, 8'd9, 8'd2, 8'd1, 8'd0};
      last_c  = {8'd80, 8'd79, 8'd78, 8'd71, 8'd70, 8'd69, 8'd62, 8'd61, 8'd60};
      clear();
      send_beats(9, 9, 81);
      repeat (10) step();
      checks++; if (win_q.size() !== 49) begin errors++; $display("FAIL frame_count got=%0d want=49", win_q.size()); end
      for (int n = 0; n < win_q.size() && n < 49; n++) begin
         checks++;
         if (win_q[n] !== exp_win(3, 9, 2 + n/7, 2 + n%7) || last_q[n] !== (n == 48)) begin
            errors++; $display("FAIL frame_win%0d got=%h last=%b", n, win_q[n], last_q[n]);
         end
      end
      if (win_q.size() == 49) begin
         checks++; if (win_q[0] !== WMAX'(first_c)) begin errors++; $display("FAIL frame_first got=%h want=%h", win_q[0], first_c); end
         checks++; if (win_q[48] !== WMAX'(last_c) || last_q[48] !== 1'b1) begin errors++; $display("FAIL frame_last got=%h last=%b want=%h", win_q[48], last_q[48], last_c); end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL frame_done_cnt got=%0d want=1", done_cnt); end
      checks++; if (acc_cnt !== 81) begin errors++; $display("FAIL frame_accepts got=%0d want=81", acc_cnt); end
   endtask

   task automatic test_stall();
      logic [71:0] w10_c, held;
      w10_c = {8'd32, 8'd31, 8'd30, 8'd23, 8'd22, 8'd21, 8'd14, 8'd13, 8'd12};
      clear();
      fork
         send_beats(9, 9, 81);
         begin
            int t;
            t = 0;
            while (!(win_q.size() == 10 && valid) && t < 500) begin step(); t++; end
            ready = 1'b0;
            held  = win;
            checks++; if (held !== w10_c) begin errors++; $display("FAIL stall_win10 got=%h want=%h", held, w10_c); end
            repeat (5) begin
               @(negedge clk);
               checks++;
               if (tready !== 1'b0 || valid !== 1'b1 || win !== held) begin
                  errors++; $display("FAIL stall_hold tready=%b valid=%b win=%h want=%h", tready, valid, win, held);
               end
               step();
            end
            ready = 1'b1;
         end
      join
      repeat (10) step();
      checks++; if (win_q.size() !== 49) begin errors++; $display("FAIL stall_count got=%0d want=49", win_q.size()); end
      for (int n = 0; n < win_q.size() && n < 49; n++) begin
         checks++;
         if (win_q[n] !== exp_win(3, 9, 2 + n/7, 2 + n%7) || last_q[n] !== (n == 48)) begin
            errors++; $display("FAIL stall_win%0d got=%h last=%b", n, win_q[n], last_q[n]);
         end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done_cnt got=%0d want=1", done_cnt); end
   endtask

   task automatic test_resize();
      logic [71:0] first_c;
      first_c = {8'd16, 8'd15, 8'd14, 8'd9, 8'd8, 8'd7, 8'd2, 8'd1, 8'd0};
      send_beats(9, 9, 81);
      repeat (10) step();
      clear();
      send_beats(7, 5, 35);
      repeat (10) step();
      checks++; if (win_q.size() !== 15) begin errors++; $display("FAIL resize_count got=%0d want=15", win_q.size()); end
      for (int n = 0; n < win_q.size() && n < 15; n++) begin
         checks++;
         if (win_q[n] !== exp_win(3, 7, 2 + n/5, 2 + n%5) || last_q[n] !== (n == 14)) begin
            errors++; $display("FAIL resize_win%0d got=%h last=%b", n, win_q[n], last_q[n]);
         end
      end
      if (win_q.size() > 0) begin
         checks++; if (win_q[0] !== WMAX'(first_c)) begin errors++; $display("FAIL resize_first got=%h want=%h", win_q[0], first_c); end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL resize_done_cnt got=%0d want=1", done_cnt); end
   endtask

   task automatic test_size_err();
      clear();
      send_beats(2, 2, 1);
      @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b want=1", err); end
      step();
      send_beats(2, 2, 3);
      repeat (10) step();
      checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL err_accepts got=%0d want=4", acc_cnt); end
      checks++; if (vseen !== 0) begin errors++; $display("FAIL err_valid_cycles got=%0d want=0", vseen); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL err_done_cnt got=%0d want=1", done_cnt); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", err); end
   endtask

   task automatic test_reset_mid();
      send_beats(9, 9, 40);
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      clear();
      send_beats(9, 9, 81);
      repeat (10) step();
      checks++; if (win_q.size() !== 49) begin errors++; $display("FAIL rmid_count got=%0d want=49", win_q.size()); end
      for (int n = 0; n < win_q.size() && n < 49; n++) begin
         checks++;
         if (win_q[n] !== exp_win(3, 9, 2 + n/7, 2 + n%7) || last_q[n] !== (n == 48)) begin
            errors++; $display("FAIL rmid_win%0d got=%h last=%b", n, win_q[n], last_q[n]);
         end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rmid_done_cnt got=%0d want=1", done_cnt); end
   endtask

   task automatic test_k5();
      logic [39:0] row0_c, row4_c;
      logic [WMAX-1:0] first;
      int waited;
      row0_c = {8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
      row4_c = {8'd40, 8'd39, 8'd38, 8'd37, 8'd36};
      clear();
      img_w = 10'd9; img_h = 10'd9;
      for (int i = 0; i < 81; i++) begin
         k5_tdata = DW'(i); k5_tvalid = 1'b1; waited = 0;
         forever begin
            @(negedge clk);
            if (k5_tready) break;
            waited++;
            if (waited > 200) begin
               checks++; errors++;
               $display("FAIL k5_send_timeout beat=%0d tready=%b want=1", i, k5_tready);
               break;
            end
         end
         step();
      end
      k5_tvalid = 1'b0;
      repeat (10) step();
      checks++; if (k5_q.size() !== 25) begin errors++; $display("FAIL k5_count got=%0d want=25", k5_q.size()); end
      for (int n = 0; n < k5_q.size() && n < 25; n++) begin
         checks++;
         if (k5_q[n] !== exp_win(5, 9, 4 + n/5, 4 + n%5) || k5_last_q[n] !== (n == 24)) begin
            errors++; $display("FAIL k5_win%0d got=%h last=%b", n, k5_q[n], k5_last_q[n]);
         end
      end
      if (k5_q.size() > 0) begin
         first = k5_q[0];
         checks++; if (first[39:0] !== row0_c) begin errors++; $display("FAIL k5_row0 got=%h want=%h", first[39:0], row0_c); end
         checks++; if (first[199:160] !== row4_c) begin errors++; $display("FAIL k5_row4 got=%h want=%h", first[199:160], row4_c); end
      end
      checks++; if (k5_done_cnt !== 1) begin errors++; $display("FAIL k5_done_cnt got=%0d want=1", k5_done_cnt); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_stall();
      test_resize();
      test_size_err();
      test_reset_mid();
      test_k5();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout reached without finishing");
      $fatal(1, "timeout");
   end

endmodule
